// File: rtl/change_dispense_sequencer.sv
// change_dispense_sequencer: greedy coin-change payout (25c, 10c, 5c) drawn from an
// internal coin inventory, one coin at a time over a 4-phase req/ack hopper handshake.
// Optional feature macro HOPPER_TIMEOUT_EN: bounds the hopper wait and adds a sticky
// FAULT state that is left only through clr_n.
module change_dispense_sequencer #(
    parameter int unsigned AMT_W  = 8,
    parameter int unsigned INV_W  = 6,
    parameter int unsigned INIT_Q = 10,
    parameter int unsigned INIT_D = 10,
    parameter int unsigned INIT_N = 10
`ifdef HOPPER_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYC = 1000
`endif
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic [AMT_W-1:0] change_cents,
    input  logic             load_inv,
    input  logic [INV_W-1:0] inv_q,
    input  logic [INV_W-1:0] inv_d,
    input  logic [INV_W-1:0] inv_n,
    output logic             disp_req,
    output logic [1:0]       disp_sel,
    input  logic             disp_ack,
    output logic             busy,
    output logic             done,
    output logic [AMT_W-1:0] short_cents,
    output logic [INV_W-1:0] cnt_q,
    output logic [INV_W-1:0] cnt_d,
    output logic [INV_W-1:0] cnt_n,
    output logic             fault
);

    localparam logic [1:0] SEL_N = 2'b00;
    localparam logic [1:0] SEL_D = 2'b01;
    localparam logic [1:0] SEL_Q = 2'b10;

`ifdef HOPPER_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_REQ,
        S_REL,
        S_DONE
`ifdef HOPPER_TIMEOUT_EN
        , S_FAULT
`endif
    } state_t;

    state_t           state, state_nxt;
    logic [AMT_W-1:0] rem, rem_nxt;
    logic [1:0]       sel_nxt;
    logic [AMT_W-1:0] short_nxt;
    logic [INV_W-1:0] cq_nxt, cd_nxt, cn_nxt;
    logic             req_nxt, busy_nxt, done_nxt;
    logic [AMT_W-1:0] coin_val_c;

`ifdef HOPPER_TIMEOUT_EN
    logic [TMO_W-1:0] tmo, tmo_nxt;
    logic             fault_nxt;
`endif

    // Value of the coin currently presented to the hopper.
    always_comb begin
        coin_val_c = AMT_W'(5);
        if (disp_sel == SEL_Q) begin
            coin_val_c = AMT_W'(25);
        end else if (disp_sel == SEL_D) begin
            coin_val_c = AMT_W'(10);
        end
    end

    // State, remainder, inventory and registered outputs.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state       <= S_IDLE;
            rem         <= '0;
            disp_sel    <= SEL_N;
            disp_req    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            short_cents <= '0;
            cnt_q       <= INV_W'(INIT_Q);
            cnt_d       <= INV_W'(INIT_D);
            cnt_n       <= INV_W'(INIT_N);
`ifdef HOPPER_TIMEOUT_EN
            tmo         <= '0;
            fault       <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            rem         <= rem_nxt;
            disp_sel    <= sel_nxt;
            disp_req    <= req_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            short_cents <= short_nxt;
            cnt_q       <= cq_nxt;
            cnt_d       <= cd_nxt;
            cnt_n       <= cn_nxt;
`ifdef HOPPER_TIMEOUT_EN
            tmo         <= tmo_nxt;
            fault       <= fault_nxt;
`endif
        end
    end

    // Next-state, greedy coin selection, inventory update and output decode.
    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        sel_nxt   = disp_sel;
        short_nxt = short_cents;
        cq_nxt    = cnt_q;
        cd_nxt    = cnt_d;
        cn_nxt    = cnt_n;
`ifdef HOPPER_TIMEOUT_EN
        // Cleared on every state entry; only waiting states count up.
        tmo_nxt   = '0;
`endif

        case (state)
            S_IDLE: begin
                if (start) begin
                    rem_nxt   = change_cents;
                    short_nxt = '0;
                    state_nxt = S_SELECT;
                end else if (load_inv) begin
                    cq_nxt = inv_q;
                    cd_nxt = inv_d;
                    cn_nxt = inv_n;
                end
            end

            S_SELECT: begin
                if (rem >= AMT_W'(25) && cnt_q != '0) begin
                    sel_nxt   = SEL_Q;
                    state_nxt = S_REQ;
                end else if (rem >= AMT_W'(10) && cnt_d != '0) begin
                    sel_nxt   = SEL_D;
                    state_nxt = S_REQ;
                end else if (rem >= AMT_W'(5) && cnt_n != '0) begin
                    sel_nxt   = SEL_N;
                    state_nxt = S_REQ;
                end else begin
                    short_nxt = rem;
                    state_nxt = S_DONE;
                end
            end

            S_REQ: begin
                if (disp_ack) begin
                    rem_nxt = rem - coin_val_c;
                    case (disp_sel)
                        SEL_Q:   cq_nxt = cnt_q - INV_W'(1);
                        SEL_D:   cd_nxt = cnt_d - INV_W'(1);
                        default: cn_nxt = cnt_n - INV_W'(1);
                    endcase
                    state_nxt = S_REL;
                end
`ifdef HOPPER_TIMEOUT_EN
                else if (tmo == TMO_W'(TIMEOUT_CYC - 1)) begin
                    short_nxt = rem;
                    state_nxt = S_FAULT;
                end else begin
                    tmo_nxt = tmo + TMO_W'(1);
                end
`endif
            end

            S_REL: begin
                if (!disp_ack) begin
                    state_nxt = S_SELECT;
                end
`ifdef HOPPER_TIMEOUT_EN
                else if (tmo == TMO_W'(TIMEOUT_CYC - 1)) begin
                    short_nxt = rem;
                    state_nxt = S_FAULT;
                end else begin
                    tmo_nxt = tmo + TMO_W'(1);
                end
`endif
            end

            S_DONE: begin
                state_nxt = S_IDLE;
            end

`ifdef HOPPER_TIMEOUT_EN
            S_FAULT: begin
                state_nxt = S_FAULT;
            end
`endif

            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Outputs are registered copies of the decoded next state.
        req_nxt  = (state_nxt == S_REQ);
        busy_nxt = (state_nxt != S_IDLE);
        done_nxt = (state_nxt == S_DONE);
`ifdef HOPPER_TIMEOUT_EN
        fault_nxt = (state_nxt == S_FAULT);
`endif
    end

`ifndef HOPPER_TIMEOUT_EN
    assign fault = 1'b0;
`endif

endmodule

// File: doc/change_dispense_sequencer.md
Name: change_dispense_sequencer

Overview:
Sequences coin-change payout for the vending machine controller after a purchase. It accepts a change amount in cents and a start pulse, and picks coins greedily (25c, then 10c, then 5c) from an internal coin inventory. It drives a one-coin-at-a-time req/ack handshake to the coin hopper mechanism and reports completion plus any amount it could not pay out.

Parameters:
AMT_W, 8, width of change amount and remainder in cents
INV_W, 6, width of each coin-type inventory counter
INIT_Q, 10, quarters in stock after reset
INIT_D, 10, dimes in stock after reset
INIT_N, 10, nickels in stock after reset
TIMEOUT_CYC, 1000, max cycles to wait for disp_ack (optional feature only)

Ports:
clk  in  1  system clock, rising edge
clr_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to pay out change_cents; sampled only in IDLE
change_cents  in  AMT_W  change to return; captured on accepted start
load_inv  in  1  one-cycle strobe loading inv_q/inv_d/inv_n; honoured only in IDLE
inv_q, inv_d, inv_n  in  INV_W each  refill values
disp_req  out  1  request hopper to eject one coin
disp_sel  out  2  coin type: 00 nickel, 01 dime, 10 quarter; stable while disp_req=1
disp_ack  in  1  hopper acknowledge (level, 4-phase)
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at end of payout
short_cents  out  AMT_W  unpaid remainder; valid from done until next accepted start
cnt_q, cnt_d, cnt_n  out  INV_W each  current inventory
fault  out  1  hopper timeout flag (optional feature only; otherwise tied 0)

Behaviour:
- Reset (async, clr_n=0): state IDLE; disp_req=0, disp_sel=00, busy=0, done=0, short_cents=0, fault=0; rem=0; cnt_q/d/n = INIT_Q/D/N.
- States: IDLE, SELECT, REQ, REL, DONE (plus FAULT with the optional feature).
- IDLE: start=1 -> rem<=change_cents, short_cents<=0, go to SELECT. Else if load_inv=1 -> load counters from inv_*. If start and load_inv are both high, start wins and load_inv is dropped.
- SELECT (1 cycle), evaluated in this order:
  - rem>=25 and cnt_q>0 -> sel=10
  - else rem>=10 and cnt_d>0 -> sel=01
  - else rem>=5 and cnt_n>0 -> sel=00
  - On any of the above: go to REQ.
  - Else: short_cents<=rem, go to DONE.
- REQ: disp_req=1 with disp_sel registered. When disp_ack=1: rem -= coin value (25/10/5); decrement the matching counter; disp_req<=0; go to REL.
- REL: wait for disp_ack=0, then go to SELECT. disp_req must stay 0 here.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency: start accepted at edge N; first disp_req high after edge N+1. For an amount of 0, done is high in the cycle after edge N+1.
- The amount is never negative. Values not a multiple of 5 leave rem<5, which is reported in short_cents.
- start and load_inv are ignored while busy=1. change_cents is not re-read mid-payout.
- Counters never underflow, because selection requires cnt>0.
- disp_ack arriving outside REQ is ignored. disp_ack already high on entry to REQ is accepted in that cycle.
- Reset mid-handshake: disp_req drops immediately (async). The in-flight coin is not counted, and inventory returns to INIT values.

Optional Feature:
Macro HOPPER_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in REQ and REL and clears on each state entry.
  - Reaching TIMEOUT_CYC -> go to FAULT: disp_req=0, fault=1, busy=1, short_cents<=rem.
  - FAULT is left only via clr_n. start is ignored while in FAULT.
- Not defined: no counter, no FAULT state, fault tied to 0, and REQ/REL wait indefinitely.

Test Plan:
- Reset, stock 10/10/10, start with 40; ack each req after 3 cycles -> disp_sel sequence 10,01,00; done pulse; short_cents=0; counts 9/9/9.
- load_inv Q=0 D=5 N=5, start with 30 -> three coins sel=01; short=0; cnt_d=2; cnt_q stays 0.
- load_inv Q=5 D=0 N=1, start with 20 -> one nickel; short_cents=15; cnt_n=0.
- start with 0 -> no disp_req; done pulses one cycle after the SELECT cycle; short=0. start with 7 -> one nickel, short=2.
- Pulse start and load_inv while busy -> both ignored; payout and counts unaffected. Assert clr_n low during REQ -> disp_req=0 at once; counts back to INIT.
- With HOPPER_TIMEOUT_EN, TIMEOUT_CYC=20, never ack -> fault=1 after 20 cycles in REQ; disp_req=0; short_cents=original amount; only reset clears it.
